// File: rtl/physical_word_align_pkg.sv
// Shared types and constants for the receive-side word aligner.
// Holds the FSM state encoding, comma constants and a counter-width helper.
package physical_word_align_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SLIP,
        ST_WAIT,
        ST_LOCKED,
        ST_FAIL
    } state_t;

    // K28.5 comma, running disparity negative
    localparam logic [9:0] K28_5_RDN = 10'h0FA;

    // Counter width for a count range of n values; never below one bit
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/physical_word_align.sv
// Word aligner: hunts for TRAIN_PATTERN, issues ISERDES bitslips, then locks.
// Ports: i_clk, i_arst_n, i_enable, i_data in; o_bitslip, o_data, o_valid,
//        o_locked, o_train_fail, o_slip_cnt out (all registered).
module physical_word_align
    import physical_word_align_pkg::*;
#(
    parameter int                    DATA_WIDTH    = 10,
    parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = K28_5_RDN,
    parameter int                    LOCK_COUNT    = 16,
    parameter int                    SLIP_WAIT     = 4,
    parameter int                    MAX_SLIPS     = 9
) (
    input  logic                  i_clk,
    input  logic                  i_arst_n,
    input  logic                  i_enable,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_bitslip,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_locked,
    output logic                  o_train_fail,
    output logic [3:0]            o_slip_cnt
);

    localparam int MW = cnt_width(LOCK_COUNT);
    localparam int WW = cnt_width(SLIP_WAIT);
    localparam int SW = cnt_width(MAX_SLIPS + 1);

    state_t          state;
    logic [MW-1:0]   match_cnt;
    logic [WW-1:0]   wait_cnt;
    logic [SW-1:0]   slip_cnt;

    // slip_cnt is itself a register, so this stays a registered output
    assign o_slip_cnt = 4'(slip_cnt);

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state        <= ST_IDLE;
            match_cnt    <= '0;
            wait_cnt     <= '0;
            slip_cnt     <= '0;
            o_bitslip    <= 1'b0;
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_locked     <= 1'b0;
            o_train_fail <= 1'b0;
        end else begin
            // Pulse and data outputs default low; only SLIP/LOCKED raise them
            o_bitslip <= 1'b0;
            o_data    <= '0;
            o_valid   <= 1'b0;
            if (!i_enable) begin
                // Disable wins over any same-cycle compare decision
                state        <= ST_IDLE;
                match_cnt    <= '0;
                wait_cnt     <= '0;
                slip_cnt     <= '0;
                o_locked     <= 1'b0;
                o_train_fail <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        match_cnt <= '0;
                        wait_cnt  <= '0;
                        slip_cnt  <= '0;
                        state     <= ST_CHECK;
                    end
                    ST_CHECK: begin
                        if (i_data == TRAIN_PATTERN) begin
                            if (match_cnt == MW'(LOCK_COUNT - 1)) begin
                                state    <= ST_LOCKED;
                                o_locked <= 1'b1;
                                o_valid  <= 1'b1;
                                o_data   <= i_data;
                            end else begin
                                match_cnt <= match_cnt + 1'b1;
                            end
                        end else begin
                            match_cnt <= '0;
                            if (slip_cnt == SW'(MAX_SLIPS)) begin
                                state        <= ST_FAIL;
                                o_train_fail <= 1'b1;
                            end else begin
                                // Count moves with the pulse so o_slip_cnt
                                // already includes the slip being issued
                                state     <= ST_SLIP;
                                o_bitslip <= 1'b1;
                                slip_cnt  <= slip_cnt + 1'b1;
                            end
                        end
                    end
                    ST_SLIP: begin
                        wait_cnt <= '0;
                        state    <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (wait_cnt == WW'(SLIP_WAIT - 1)) begin
                            wait_cnt <= '0;
                            state    <= ST_CHECK;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        // Lock is sticky; the link layer drops i_enable
                        o_data  <= i_data;
                        o_valid <= 1'b1;
                    end
                    ST_FAIL: begin
                        state <= ST_FAIL;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
